// File: rtl/vpu_pkg.sv
// Shared types for the vector engine: opcodes, instruction layout, FSM states and
// opcode classification helpers.
package vpu_pkg;

   localparam int unsigned InstAddrW = 5;

   typedef enum logic [3:0] {
      OpAdd  = 4'd0,
      OpSub  = 4'd1,
      OpRelu = 4'd2,
      OpMul  = 4'd3,
      OpMax  = 4'd4,
      OpMin  = 4'd5
   } opcode_e;

   // Low 28 instruction bits; bits [31:28] are reserved and never latched.
   typedef struct packed {
      logic [3:0]           vlen_m1;
      logic [InstAddrW-1:0] const_addr;
      logic [InstAddrW-1:0] c_addr;
      logic [InstAddrW-1:0] b_addr;
      logic [InstAddrW-1:0] a_addr;
      logic [3:0]           opcode;
   } inst_t;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StWait,
      StExec,
      StWr,
      StDone
   } state_t;

   function automatic logic is_legal(input logic [3:0] op);
      return op <= OpMin;
   endfunction

   function automatic logic is_unary(input logic [3:0] op);
      return op == OpRelu;
   endfunction

endpackage

// File: rtl/vpu_vec_engine_if.sv
// Instruction handshake and dual-read / single-write scratchpad bus of the vector engine.
interface vpu_vec_engine_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LANES  = 4,
   parameter int unsigned ADDR_W = 13
);
   logic [31:0]             inst;
   logic                    inst_valid;
   logic                    inst_ready;
   logic                    rd_en;
   logic [ADDR_W-1:0]       addr_a;
   logic [ADDR_W-1:0]       addr_b;
   logic [LANES*DATA_W-1:0] rdata_a;
   logic [LANES*DATA_W-1:0] rdata_b;
   logic                    wr_en;
   logic [ADDR_W-1:0]       addr_c;
   logic [LANES*DATA_W-1:0] wdata_c;
   logic                    busy;
   logic                    done;
   logic                    err;

   modport slave (
      input  inst, inst_valid, rdata_a, rdata_b,
      output inst_ready, rd_en, addr_a, addr_b, wr_en, addr_c, wdata_c, busy, done, err
   );

   modport master (
      output inst, inst_valid, rdata_a, rdata_b,
      input  inst_ready, rd_en, addr_a, addr_b, wr_en, addr_c, wdata_c, busy, done, err
   );
endinterface

// File: rtl/vpu_lane_alu.sv
// One combinational lane of the vector ALU; signed two's complement, wrapping results.
module vpu_lane_alu
   import vpu_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
);
   logic signed [DATA_W-1:0] sa;
   logic signed [DATA_W-1:0] sb;
   logic        [DATA_W-1:0] prod;

   // Low half of the product is identical for signed and unsigned operands.
   assign prod = a * b;

   always_comb begin
      sa     = $signed(a);
      sb     = $signed(b);
      result = '0;
      case (op)
         OpAdd:   result = a + b;
         OpSub:   result = a - b;
         OpRelu:  result = a[DATA_W-1] ? '0 : a;
         OpMul:   result = prod;
         OpMax:   result = (sa > sb) ? a : b;
         OpMin:   result = (sa < sb) ? a : b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/vpu_vec_engine.sv
// Vector engine: runs one instruction over VLEN beats of LANES lanes, reading A/B from the
// scratchpad with a fixed latency and writing C back one word per beat.
module vpu_vec_engine
   import vpu_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned LANES     = 4,
   parameter int unsigned ADDR_W    = 13,
   parameter int unsigned MEM_LAT   = 2,
   parameter int unsigned INST_ADDR = 5
) (
   input logic             clk,
   input logic             rst_n,
   vpu_vec_engine_if.slave bus
);
   localparam int unsigned WordW = LANES * DATA_W;
   localparam int unsigned LatW  = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

   state_t            state_q, state_d;
   inst_t             inst_q, inst_d;
   logic [3:0]        beat_q, beat_d;
   logic [LatW-1:0]   lat_q, lat_d;
   logic [WordW-1:0]  a_q, a_d;
   logic [WordW-1:0]  b_q, b_d;
   logic [WordW-1:0]  result_q, result_d;
   logic [DATA_W-1:0] const_q, const_d;
   logic              err_q, err_d;
   logic              live_q;
   logic              cmode;
   logic [WordW-1:0]  b_eff;
   logic [WordW-1:0]  alu_out;
   logic [ADDR_W-1:0] beat_ext;

   function automatic logic [ADDR_W-1:0] ext(input logic [INST_ADDR-1:0] f);
      return ADDR_W'(f);
   endfunction

   assign cmode    = (inst_q.b_addr == '0) && (inst_q.const_addr != '0) &&
                     !is_unary(inst_q.opcode);
   assign b_eff    = cmode ? {LANES{const_q}} : b_q;
   assign beat_ext = ADDR_W'(beat_q);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      vpu_lane_alu #(
         .DATA_W (DATA_W)
      ) u_alu (
         .op     (inst_q.opcode),
         .a      (a_q[l*DATA_W +: DATA_W]),
         .b      (b_eff[l*DATA_W +: DATA_W]),
         .result (alu_out[l*DATA_W +: DATA_W])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         inst_q   <= '0;
         beat_q   <= '0;
         lat_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         const_q  <= '0;
         err_q    <= 1'b0;
         live_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         inst_q   <= inst_d;
         beat_q   <= beat_d;
         lat_q    <= lat_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         const_q  <= const_d;
         err_q    <= err_d;
         live_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      inst_d   = inst_q;
      beat_d   = beat_q;
      lat_d    = lat_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      const_d  = const_q;
      err_d    = err_q;
      unique case (state_q)
         StIdle: begin
            if (bus.inst_valid && live_q) begin
               inst_d  = bus.inst[27:0];
               beat_d  = '0;
               err_d   = !is_legal(bus.inst[3:0]);
               state_d = is_legal(bus.inst[3:0]) ? StRd : StDone;
            end
         end
         StRd: begin
            lat_d   = LatW'(MEM_LAT);
            state_d = StWait;
         end
         StWait: begin
            if (lat_q == LatW'(1)) begin
               a_d = bus.rdata_a;
               // The constant is fetched once, on beat 0, and reused for every beat.
               if (!is_unary(inst_q.opcode)) begin
                  if (cmode) begin
                     if (beat_q == '0) const_d = bus.rdata_b[DATA_W-1:0];
                  end else begin
                     b_d = bus.rdata_b;
                  end
               end
               state_d = StExec;
            end else begin
               lat_d = lat_q - LatW'(1);
            end
         end
         StExec: begin
            result_d = alu_out;
            state_d  = StWr;
         end
         StWr: begin
            if (beat_q == inst_q.vlen_m1) begin
               state_d = StDone;
            end else begin
               beat_d  = beat_q + 4'd1;
               state_d = StRd;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.inst_ready = live_q && (state_q == StIdle);
      bus.busy       = (state_q != StIdle);
      bus.done       = (state_q == StDone);
      bus.err        = (state_q == StDone) && err_q;
      bus.rd_en      = 1'b0;
      bus.addr_a     = '0;
      bus.addr_b     = '0;
      bus.wr_en      = 1'b0;
      bus.addr_c     = '0;
      bus.wdata_c    = '0;
      case (state_q)
         StRd: begin
            bus.rd_en  = 1'b1;
            bus.addr_a = ext(inst_q.a_addr) + beat_ext;
            if (cmode) bus.addr_b = (beat_q == '0) ? ext(inst_q.const_addr) : '0;
            else       bus.addr_b = ext(inst_q.b_addr) + beat_ext;
         end
         StWr: begin
            bus.wr_en   = 1'b1;
            bus.addr_c  = ext(inst_q.c_addr) + beat_ext;
            bus.wdata_c = result_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_vpu_vec_engine.sv
// Directed bench for vpu_vec_engine: a vector table of single-beat instructions plus
// hand-written multi-beat, constant-mode, reset-abort and back-to-back sequences.
module tb_vpu_vec_engine;
   localparam int unsigned DW = 32;
   localparam int unsigned LN = 4;
   localparam int unsigned AW = 13;
   localparam int unsigned ML = 2;
   localparam int unsigned W  = LN * DW;

   logic clk;
   logic rst_n;

   vpu_vec_engine_if #(.DATA_W(DW), .LANES(LN), .ADDR_W(AW)) bus ();

   vpu_vec_engine #(
      .DATA_W    (DW),
      .LANES     (LN),
      .ADDR_W    (AW),
      .MEM_LAT   (ML),
      .INST_ADDR (5)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scratchpad model: data appears ML cycles after rd_en, garbage otherwise.
   logic [W-1:0] mem [0:(1<<AW)-1];
   logic [W-1:0] pa [ML];
   logic [W-1:0] pb [ML];
   logic         pv [ML];
   int           cyc;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      pa[0] <= mem[bus.addr_a];
      pb[0] <= mem[bus.addr_b];
      pv[0] <= bus.rd_en;
      for (int i = 1; i < ML; i++) begin
         pa[i] <= pa[i-1];
         pb[i] <= pb[i-1];
         pv[i] <= pv[i-1];
      end
      if (bus.wr_en) mem[bus.addr_c] = bus.wdata_c;
   end

   assign bus.rdata_a = pv[ML-1] ? pa[ML-1] : {LN{32'hDEAD_BEEF}};
   assign bus.rdata_b = pv[ML-1] ? pb[ML-1] : {LN{32'hBAD0_CAFE}};

   typedef struct {
      logic [AW-1:0] a;
      logic [W-1:0]  d;
   } wr_t;

   wr_t           wq[$];
   logic [AW-1:0] ra[$];
   logic [AW-1:0] rb[$];
   int            overlap;

   always @(negedge clk) begin
      if (bus.wr_en) wq.push_back('{a: bus.addr_c, d: bus.wdata_c});
      if (bus.rd_en) begin
         ra.push_back(bus.addr_a);
         rb.push_back(bus.addr_b);
      end
      if (bus.rd_en && bus.wr_en) overlap++;
   end

   int checks;
   int failures;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] pack(input int l0, input int l1, input int l2, input int l3);
      return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
   endfunction

   // Reserved bits set on purpose; they must be ignored.
   function automatic logic [31:0] mk(input int op, input int a, input int b, input int c,
                                      input int k, input int vm1);
      return {4'hA, 4'(vm1), 5'(k), 5'(c), 5'(b), 5'(a), 4'(op)};
   endfunction

   function automatic logic [AW-1:0] fa(input int v);
      return AW'(v);
   endfunction

   task automatic clear_q();
      wq.delete();
      ra.delete();
      rb.delete();
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (bus.inst_ready) ok = 1'b1;
      end
   endtask

   // Issue one instruction, drop valid after accept, return done latency and err.
   task automatic run(input logic [31:0] ins, input int budget, output int lat, output logic e,
                      output int viol);
      bit ok;
      int t0;
      wait_ready(ok);
      chk("ready_before_issue", {127'd0, ok}, 1);
      bus.inst       = ins;
      bus.inst_valid = 1'b1;
      t0             = cyc;
      @(posedge clk);
      #1;
      bus.inst_valid = 1'b0;
      bus.inst       = $urandom();
      lat  = -1;
      e    = 1'b0;
      viol = 0;
      for (int i = 0; i < budget && lat < 0; i++) begin
         @(negedge clk);
         if (bus.inst_ready) viol++;
         if (bus.done) begin
            lat = cyc - t0;
            e   = bus.err;
         end
      end
      #1;
   endtask

   typedef struct {
      string        name;
      logic [31:0]  inst;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      int           lat;
      logic         err;
   } vec_t;

   vec_t vt[8];

   initial begin
      int   lat;
      int   viol;
      logic e;
      bit   ok;
      bit   got;
      int   nrd;
      int   d1;

      vt[0] = '{"add", mk(0, 3, 5, 7, 0, 0), pack(1, 2, 3, 4), pack(10, 20, 30, 40),
                pack(11, 22, 33, 44), 6, 1'b0};
      vt[1] = '{"sub", mk(1, 10, 11, 12, 0, 0), pack(5, 0, -3, 100), pack(7, -4, -3, 1),
                pack(-2, 4, 0, 99), 6, 1'b0};
      vt[2] = '{"mul", mk(3, 13, 14, 15, 0, 0), pack(3, -4, 'h10000, 7),
                pack(5, 6, 'h10000, -1), pack(15, -24, 0, -7), 6, 1'b0};
      vt[3] = '{"max", mk(4, 16, 17, 18, 0, 0), pack(-5, 3, 'h7FFFFFFF, -1),
                pack(2, 3, -1, -2), pack(2, 3, 'h7FFFFFFF, -1), 6, 1'b0};
      vt[4] = '{"min", mk(5, 16, 17, 19, 0, 0), pack(-5, 3, 'h7FFFFFFF, -1),
                pack(2, 3, -1, -2), pack(-5, 3, -1, -2), 6, 1'b0};
      vt[5] = '{"ill12", mk(12, 0, 0, 2, 0, 3), '0, '0, '0, 1, 1'b1};
      vt[6] = '{"subwrap", mk(1, 20, 21, 22, 0, 0), pack('h7FFFFFFF, 'h80000000, 1, 0),
                pack(-1, 1, 2, 0), pack('h80000000, 'h7FFFFFFF, -1, 0), 6, 1'b0};
      vt[7] = '{"ill6", mk(6, 1, 1, 2, 0, 0), '0, '0, '0, 1, 1'b1};

      checks     = 0;
      failures   = 0;
      overlap    = 0;
      cyc        = 0;
      bus.inst       = '0;
      bus.inst_valid = 1'b0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      for (int i = 0; i < ML; i++) begin
         pa[i] = '0;
         pb[i] = '0;
         pv[i] = 1'b0;
      end

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {122'd0, bus.inst_ready, bus.rd_en, bus.wr_en, bus.busy, bus.done,
                       bus.err}, '0);
      chk("rst_addr", {89'd0, bus.addr_a, bus.addr_b, bus.addr_c}, '0);
      chk("rst_wdata", bus.wdata_c, '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready_after", {126'd0, bus.inst_ready, bus.busy}, 2);

      for (int i = 0; i < 8; i++) begin
         mem[vt[i].inst[8:4]]  = vt[i].a;
         mem[vt[i].inst[13:9]] = vt[i].b;
         clear_q();
         run(vt[i].inst, 40, lat, e, viol);
         chk({vt[i].name, "_lat"}, W'(lat), W'(vt[i].lat));
         chk({vt[i].name, "_err"}, W'(e), W'(vt[i].err));
         chk({vt[i].name, "_ready_busy"}, W'(viol), 0);
         chk({vt[i].name, "_nwr"}, W'(wq.size()), W'(!vt[i].err));
         chk({vt[i].name, "_nrd"}, W'(ra.size()), W'(!vt[i].err));
         if (wq.size() > 0 && ra.size() > 0) begin
            chk({vt[i].name, "_waddr"}, W'(wq[0].a), W'(vt[i].inst[18:14]));
            chk({vt[i].name, "_wdata"}, wq[0].d, vt[i].exp);
            chk({vt[i].name, "_raddr_a"}, W'(ra[0]), W'(vt[i].inst[8:4]));
            chk({vt[i].name, "_raddr_b"}, W'(rb[0]), W'(vt[i].inst[13:9]));
         end
      end

      // RELU over three beats; port B contents must not matter.
      mem[0] = pack(-1, 5, -7, 0);
      mem[1] = pack(3, -3, 9, -9);
      mem[2] = pack(0, 0, 0, 0);
      mem[4] = pack(100, -100, 100, -100);
      mem[5] = pack(10, 20, 30, 40);
      mem[6] = pack(-50, -50, -50, -50);
      clear_q();
      run(mk(2, 0, 4, 24, 0, 2), 60, lat, e, viol);
      chk("relu_lat", W'(lat), 16);
      chk("relu_err", W'(e), 0);
      chk("relu_nwr", W'(wq.size()), 3);
      if (wq.size() == 3) begin
         chk("relu_w0", {wq[0].a, wq[0].d}, {fa(24), pack(0, 5, 0, 0)});
         chk("relu_w1", {wq[1].a, wq[1].d}, {fa(25), pack(3, 0, 9, 0)});
         chk("relu_w2", {wq[2].a, wq[2].d}, {fa(26), pack(0, 0, 0, 0)});
      end

      // Constant-mode MUL: lane 0 of word 9 broadcast, other lanes deliberately nonzero.
      mem[9]  = pack(-2, 99, 98, 97);
      mem[28] = pack(1, 2, 3, 4);
      mem[29] = pack(5, 6, 7, 8);
      clear_q();
      run(mk(3, 28, 0, 10, 9, 1), 40, lat, e, viol);
      chk("cmul_lat", W'(lat), 11);
      chk("cmul_nrd", W'(ra.size()), 2);
      chk("cmul_nwr", W'(wq.size()), 2);
      if (ra.size() == 2) begin
         chk("cmul_addr_a", W'({ra[0], ra[1]}), W'({fa(28), fa(29)}));
         chk("cmul_addr_b", W'({rb[0], rb[1]}), W'({fa(9), fa(0)}));
      end
      if (wq.size() == 2) begin
         chk("cmul_w0", {wq[0].a, wq[0].d}, {fa(10), pack(-2, -4, -6, -8)});
         chk("cmul_w1", {wq[1].a, wq[1].d}, {fa(11), pack(-10, -12, -14, -16)});
      end

      // Reset during the WAIT of beat 1 of a 4-beat ADD.
      clear_q();
      wait_ready(ok);
      chk("abort_ready", {127'd0, ok}, 1);
      bus.inst       = mk(0, 0, 4, 27, 0, 3);
      bus.inst_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.inst_valid = 1'b0;
      got = 1'b0;
      nrd = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.rd_en) nrd++;
         else if (nrd == 2) got = 1'b1;
      end
      chk("abort_reached_wait", {127'd0, got}, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_ctrl", {122'd0, bus.inst_ready, bus.rd_en, bus.wr_en, bus.busy, bus.done,
                         bus.err}, '0);
      chk("abort_addr", {89'd0, bus.addr_a, bus.addr_b, bus.addr_c}, '0);
      chk("abort_wdata", bus.wdata_c, '0);
      repeat (3) @(negedge clk);
      chk("abort_hold", {122'd0, bus.inst_ready, bus.rd_en, bus.wr_en, bus.busy, bus.done,
                         bus.err}, '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready_after", {127'd0, bus.inst_ready}, 1);
      repeat (20) @(negedge clk);
      #1;
      chk("abort_nwr", W'(wq.size()), 1);
      clear_q();
      run(mk(0, 3, 5, 30, 0, 0), 40, lat, e, viol);
      chk("post_rst_lat", W'(lat), 6);
      chk("post_rst_nwr", W'(wq.size()), 1);
      if (wq.size() == 1) chk("post_rst_w", {wq[0].a, wq[0].d}, {fa(30), pack(11, 22, 33, 44)});

      // Back-to-back: valid held high, second instruction presented once the first is done.
      clear_q();
      wait_ready(ok);
      bus.inst       = mk(0, 3, 5, 31, 0, 0);
      bus.inst_valid = 1'b1;
      viol = 0;
      d1   = -1;
      for (int i = 0; i < 40 && d1 < 0; i++) begin
         @(negedge clk);
         if (bus.inst_ready) viol++;
         if (bus.done) begin
            d1       = cyc;
            bus.inst = mk(1, 20, 21, 1, 0, 0);
         end
      end
      chk("b2b_first_done", W'(d1 >= 0), 1);
      chk("b2b_ready_busy", W'(viol), 0);
      @(negedge clk);
      chk("b2b_ready_idle", {127'd0, bus.inst_ready}, 1);
      @(posedge clk);
      #1;
      bus.inst_valid = 1'b0;
      lat = -1;
      for (int i = 0; i < 40 && lat < 0; i++) begin
         @(negedge clk);
         if (bus.done) lat = cyc - d1;
      end
      #1;
      chk("b2b_second_done", W'(lat), 7);
      chk("b2b_nwr", W'(wq.size()), 2);
      if (wq.size() == 2) begin
         chk("b2b_w0", {wq[0].a, wq[0].d}, {fa(31), pack(11, 22, 33, 44)});
         chk("b2b_w1", {wq[1].a, wq[1].d}, {fa(1), pack('h80000000, 'h7FFFFFFF, -1, 0)});
      end

      chk("rd_wr_overlap", W'(overlap), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
